led_pattern_sched: RTL and testbench



---
 rtl/led_pattern_sched.sv | 153 +++++++++++++++
 tb/tb_led_pattern_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sched.sv
// led_pattern_sched: round-robin arbitrated byte FIFO feeding an LSB-first LED serializer.
// Optional build macro LED_SCHED_REPEAT_EN: replay the last byte instead of idling when the FIFO runs dry.
module led_pattern_sched #(
  parameter int DEPTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   a_valid,
  input  logic [7:0]             a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [7:0]             b_data,
  output logic                   b_ready,
  output logic                   user_led0,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic       RR_A     = 1'b0;
  localparam logic       RR_B     = 1'b1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic          rr_r;
  logic [0:0]    state_r;
  logic [7:0]    sreg_r;
  logic [2:0]    bit_idx_r;
  logic [HW-1:0] hold_r;

  logic          full_s;
  logic          nonempty_s;
  logic          wr_a_s;
  logic          wr_b_s;
  logic          push_s;
  logic          pop_s;
  logic          hold_last_s;
  logic          byte_end_s;
  logic [7:0]    wdata_s;
  logic [7:0]    head_s;

  // Handshake and pop decisions; full looks only at the registered level, so a pop never frees a slot early.
  always_comb begin
    full_s      = (level == LW'(DEPTH));
    nonempty_s  = (level != {LW{1'b0}});
    a_ready     = !full_s && !(b_valid && (rr_r == RR_B));
    b_ready     = !full_s && !(a_valid && (rr_r == RR_A));
    wr_a_s      = a_valid && a_ready;
    wr_b_s      = b_valid && b_ready;
    push_s      = wr_a_s || wr_b_s;
    if (wr_a_s) begin
      wdata_s = a_data;
    end else begin
      wdata_s = b_data;
    end
    head_s      = mem_r[rd_ptr_r];
    hold_last_s = (hold_r == HW'(BIT_CYCLES - 1));
    byte_end_s  = (state_r == ST_SHIFT) && hold_last_s && (bit_idx_r == 3'd7);
    if (state_r == ST_IDLE) begin
      pop_s = nonempty_s;
    end else begin
      pop_s = byte_end_s && nonempty_s;
    end
  end

  // Preference flips to the other requester after every accepted write.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rr_r <= RR_A;
    end else if (wr_a_s) begin
      rr_r <= RR_B;
    end else if (wr_b_s) begin
      rr_r <= RR_A;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Pattern storage is deliberately left unreset.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level    <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Serializer: a pop loads the byte and shows bit 0 at once, so back-to-back bytes leave no gap.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_IDLE;
      sreg_r    <= 8'h00;
      bit_idx_r <= 3'd0;
      hold_r    <= {HW{1'b0}};
      user_led0 <= 1'b0;
      busy      <= 1'b0;
    end else if (pop_s) begin
      state_r   <= ST_SHIFT;
      sreg_r    <= head_s;
      bit_idx_r <= 3'd0;
      hold_r    <= {HW{1'b0}};
      user_led0 <= head_s[0];
      busy      <= 1'b1;
    end else if (state_r == ST_SHIFT) begin
      if (!hold_last_s) begin
        hold_r <= hold_r + HW'(1);
      end else if (bit_idx_r != 3'd7) begin
        hold_r    <= {HW{1'b0}};
        bit_idx_r <= bit_idx_r + 3'd1;
        user_led0 <= sreg_r[bit_idx_r + 3'd1];
      end else begin
        hold_r    <= {HW{1'b0}};
        bit_idx_r <= 3'd0;
`ifdef LED_SCHED_REPEAT_EN
        user_led0 <= sreg_r[0];
`else
        state_r   <= ST_IDLE;
        user_led0 <= 1'b0;
        busy      <= 1'b0;
`endif
      end
    end else begin
      user_led0 <= 1'b0;
      busy      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_sched.sv
// Directed bench for led_pattern_sched: accepted bytes go into a scoreboard queue and every
// busy cycle the expected LED bit is rebuilt from the queued byte and compared.
module tb_led_pattern_sched;
  localparam int DEPTH    = 8;
  localparam int BC       = 2;
  localparam int BYTE_CYC = 8 * BC;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          a_valid;
  logic [7:0]    a_data;
  logic          a_ready;
  logic          b_valid;
  logic [7:0]    b_data;
  logic          b_ready;
  logic          user_led0;
  logic          busy;
  logic [LW-1:0] level;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  logic [7:0] cur = 8'h00;
  int         pos = 0;
  int         busy_cycles = 0;
  int         busy_rises = 0;
  logic       busy_prev = 1'b0;
  bit         arb_on = 1'b0;
  logic       arb_exp_b = 1'b0;
  int         arb_n = 0;
  int         acc = 0;
  bit         saw_full = 1'b0;

  led_pattern_sched #(.DEPTH(DEPTH), .BIT_CYCLES(BC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .user_led0(user_led0), .busy(busy), .level(level)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consume one expected LED bit per busy cycle.
  task automatic monitor();
    if (busy === 1'b1) begin
      busy_cycles++;
      if (!busy_prev) busy_rises++;
      if (pos == 0) begin
        if (sb.size() != 0) begin
          cur = sb.pop_front();
        end else begin
`ifndef LED_SCHED_REPEAT_EN
          check("sb_has_byte", 32'(sb.size() != 0), 32'd1);
`endif
        end
      end
      check("led_bit", 32'(user_led0), 32'(cur[pos / BC]));
      pos = (pos + 1) % BYTE_CYC;
    end else begin
      check("led_idle", 32'(user_led0), 32'd0);
      check("byte_truncated", 32'(pos), 32'd0);
    end
    busy_prev = busy;
  endtask

  // Sample the handshake just before the edge, check outputs 1 time unit after it.
  task automatic tick();
    logic pa, pb;
    logic [7:0] da, db;
    #1;
    pa = a_valid && a_ready;
    pb = b_valid && b_ready;
    da = a_data;
    db = b_data;
    check("one_write", 32'(pa && pb), 32'd0);
    if (arb_on && (pa || pb)) begin
      check("rr_order", 32'(pb), 32'(arb_exp_b));
      arb_exp_b = !pb;
      arb_n++;
    end
    @(posedge sys_clk);
    #1;
    monitor();
    acc = pa ? 1 : (pb ? 2 : 0);
    if (pa) sb.push_back(da);
    else if (pb) sb.push_back(db);
  endtask

  task automatic write_a(input logic [7:0] d);
    int n;
    n = 0;
    a_valid = 1'b1;
    a_data  = d;
    do begin
      tick();
      n++;
    end while (acc != 1 && n < 200);
    check("write_a_accept", 32'(acc), 32'd1);
    a_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || level !== '0) && n < 2000) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 2000), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check("rst_led", 32'(user_led0), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    sb.delete();
    pos = 0;
    busy_prev = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    a_valid = 1'b0; a_data = 8'h00;
    b_valid = 1'b0; b_data = 8'h00;
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_led", 32'(user_led0), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    check("rst_b_ready", 32'(b_ready), 32'd1);
    tick();
    tick();
    sys_rst_n = 1'b1;

    // 0xA5 once: level 1 after E0, first bit after E1.
    a_valid = 1'b1;
    a_data  = 8'hA5;
    tick();
    check("a5_accept", 32'(acc), 32'd1);
    check("a5_e0_level", 32'(level), 32'd1);
    check("a5_e0_busy", 32'(busy), 32'd0);
    check("a5_e0_led", 32'(user_led0), 32'd0);
    a_valid = 1'b0;
    tick();
    check("a5_e1_level", 32'(level), 32'd0);
    check("a5_e1_busy", 32'(busy), 32'd1);
    check("a5_e1_led", 32'(user_led0), 32'd1);

`ifdef LED_SCHED_REPEAT_EN
    repeat (BYTE_CYC * 2) tick();
    check("a5_replay_busy", 32'(busy), 32'd1);
    do_reset();

    write_a(8'h03);
    repeat (BYTE_CYC * 2 + 5) tick();
    check("repeat_busy", 32'(busy), 32'd1);
    write_a(8'h5A);
    repeat (BYTE_CYC * 3) tick();
    check("repeat_busy_after", 32'(busy), 32'd1);
    check("repeat_takeover", 32'(sb.size()), 32'd0);
    do_reset();
`else
    repeat (BYTE_CYC - 1) tick();
    check("a5_last_busy", 32'(busy), 32'd1);
    check("a5_last_led", 32'(user_led0), 32'd1);
    tick();
    check("a5_end_busy", 32'(busy), 32'd0);
    check("a5_end_led", 32'(user_led0), 32'd0);
    wait_idle("a5_idle");

    // Both requesters valid every cycle from reset.
    do_reset();
    arb_on = 1'b1; arb_exp_b = 1'b0; arb_n = 0; saw_full = 1'b0;
    a_valid = 1'b1; a_data = 8'h01;
    b_valid = 1'b1; b_data = 8'h02;
    repeat (30) begin
      tick();
      if (level == LW'(DEPTH)) begin
        saw_full = 1'b1;
        check("full_a_ready", 32'(a_ready), 32'd0);
        check("full_b_ready", 32'(b_ready), 32'd0);
      end
    end
    check("arb_saw_full", 32'(saw_full), 32'd1);
    check("arb_accepts", 32'(arb_n >= 4), 32'd1);
    arb_on = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    wait_idle("arb_idle");

    // Three bytes back to back: one unbroken busy window.
    busy_cycles = 0;
    busy_rises = 0;
    write_a(8'hC3);
    write_a(8'h3C);
    write_a(8'h96);
    wait_idle("stream_idle");
    check("stream_busy_cycles", 32'(busy_cycles), 32'(3 * BYTE_CYC));
    check("stream_busy_rises", 32'(busy_rises), 32'd1);

    // Fill to DEPTH, check refusal, then room after the first pop.
    for (int i = 0; i < DEPTH + 1; i++) write_a(8'h10 + 8'(i));
    check("fill_level", 32'(level), 32'(DEPTH));
    begin
      int n;
      n = 0;
      a_valid = 1'b1;
      a_data  = 8'hEE;
      while (level == LW'(DEPTH) && n < 40) begin
        check("fill_refuse", 32'(a_ready), 32'd0);
        tick();
        check("fill_no_accept", 32'(acc), 32'd0);
        n++;
      end
      check("pop_level", 32'(level), 32'(DEPTH - 1));
      check("pop_a_ready", 32'(a_ready), 32'd1);
      tick();
      check("refill_accept", 32'(acc), 32'd1);
      a_valid = 1'b0;
    end
    wait_idle("fill_idle");

    // Reset in bit 3 with two bytes queued, then a fresh 0x80.
    write_a(8'hFF);
    write_a(8'h22);
    write_a(8'h33);
    check("pre_rst_level", 32'(level), 32'd2);
    begin
      int n;
      n = 0;
      while (pos != 7 && n < 40) begin
        tick();
        n++;
      end
      check("pre_rst_pos", 32'(pos), 32'd7);
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_led", 32'(user_led0), 32'd1);
    do_reset();
    check("post_rst_a_ready", 32'(a_ready), 32'd1);
    write_a(8'h80);
    tick();
    check("r80_bit0", 32'(user_led0), 32'd0);
    check("r80_busy", 32'(busy), 32'd1);
    wait_idle("r80_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
